// File: rtl/gate_selftest.sv
// Self-test sequencer for the AND/OR/NOT/NAND/NOR gate library: walks {a,b} through 00..11 and checks the gate outputs.
// Latency: 4*SETTLE cycles from the start edge to done; each vector is held SETTLE cycles, then sampled.
// Backpressure: none; start is ignored while busy, and results hold in DONE until the next start or reset.
module gate_selftest #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  input  logic       y_nand,
  input  logic       y_nor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_mask,
  output logic [3:0] err_vec
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] vec, vec_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [4:0] err_mask_nxt;
  logic [3:0] err_vec_nxt;
  logic [4:0] mis;

  // One bit per gate, set when the observed output disagrees with the truth table for the current {a,b}.
  assign mis = {y_nor ^ ~(a | b), y_nand ^ ~(a & b), y_not ^ ~a, y_or ^ (a | b), y_and ^ (a & b)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= 2'd0;
      cnt      <= 8'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 5'd0;
      err_vec  <= 4'd0;
    end else begin
      state    <= state_nxt;
      vec      <= vec_nxt;
      cnt      <= cnt_nxt;
      a        <= a_nxt;
      b        <= b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      err_mask <= err_mask_nxt;
      err_vec  <= err_vec_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    cnt_nxt      = cnt;
    a_nxt        = a;
    b_nxt        = b;
    busy_nxt     = busy;
    done_nxt     = done;
    pass_nxt     = pass;
    err_mask_nxt = err_mask;
    err_vec_nxt  = err_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt    = APPLY;
          vec_nxt      = 2'd0;
          cnt_nxt      = 8'd0;
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
          err_mask_nxt = 5'd0;
          err_vec_nxt  = 4'd0;
        end
      end
      APPLY: begin
        if (cnt != LAST) begin
          cnt_nxt = cnt + 8'd1;
        end else begin
          err_mask_nxt     = err_mask | mis;
          err_vec_nxt[vec] = err_vec[vec] | (|mis);
          if (vec != 2'd3) begin
            vec_nxt          = vec + 2'd1;
            cnt_nxt          = 8'd0;
            {a_nxt, b_nxt}   = vec + 2'd1;
          end else begin
            // The accumulated mask already includes this final sample, so it alone decides pass.
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            pass_nxt  = (err_mask_nxt == 5'd0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: three instances (SETTLE 2, 1, 255) driving truth-table gate models with injectable faults.
module tb_gate_selftest;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] start;
  // tt[i][g][v]: output of gate g of instance i when {a,b}=v; g order and,or,not,nand,nor.
  logic [3:0] tt [3][5];

  wire [2:0] a, b, busy, done, pass;
  wire [2:0] y_and, y_or, y_not, y_nand, y_nor;
  wire [4:0] err_mask [3];
  wire [3:0] err_vec  [3];

  int checks   = 0;
  int failures = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int S = (i == 0) ? 2 : (i == 1) ? 1 : 255;
    assign y_and[i]  = tt[i][0][{a[i], b[i]}];
    assign y_or[i]   = tt[i][1][{a[i], b[i]}];
    assign y_not[i]  = tt[i][2][{a[i], b[i]}];
    assign y_nand[i] = tt[i][3][{a[i], b[i]}];
    assign y_nor[i]  = tt[i][4][{a[i], b[i]}];
    gate_selftest #(.SETTLE(S)) u_dut (
      .clk      (clk),
      .rst      (rst[i]),
      .start    (start[i]),
      .a        (a[i]),
      .b        (b[i]),
      .y_and    (y_and[i]),
      .y_or     (y_or[i]),
      .y_not    (y_not[i]),
      .y_nand   (y_nand[i]),
      .y_nor    (y_nor[i]),
      .busy     (busy[i]),
      .done     (done[i]),
      .pass     (pass[i]),
      .err_mask (err_mask[i]),
      .err_vec  (err_vec[i])
    );
  end

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Ideal gate value for gate g at inputs (va,vb), from plain boolean arithmetic.
  function automatic logic ideal(input int g, input int va, input int vb);
    case (g)
      0:       return logic'(va * vb);
      1:       return logic'((va + vb) > 0);
      2:       return logic'(1 - va);
      3:       return logic'(1 - va * vb);
      default: return logic'((va + vb) == 0);
    endcase
  endfunction

  task automatic ref_model(input int i, output logic [4:0] em, output logic [3:0] ev);
    em = '0;
    ev = '0;
    for (int v = 0; v < 4; v++)
      for (int g = 0; g < 5; g++)
        if (tt[i][g][v] != ideal(g, v / 2, v % 2)) begin
          em[g] = 1'b1;
          ev[v] = 1'b1;
        end
  endtask

  task automatic set_good(input int i);
    for (int g = 0; g < 5; g++)
      for (int v = 0; v < 4; v++)
        tt[i][g][v] = ideal(g, v / 2, v % 2);
  endtask

  task automatic chk_idle_zero(input int i, input string tag);
    chk($sformatf("%s_a", tag), 32'(a[i]), 0);
    chk($sformatf("%s_b", tag), 32'(b[i]), 0);
    chk($sformatf("%s_busy", tag), 32'(busy[i]), 0);
    chk($sformatf("%s_done", tag), 32'(done[i]), 0);
    chk($sformatf("%s_pass", tag), 32'(pass[i]), 0);
    chk($sformatf("%s_mask", tag), 32'(err_mask[i]), 0);
    chk($sformatf("%s_vec", tag), 32'(err_vec[i]), 0);
  endtask

  // One-cycle start pulse, then every cycle of the run is compared against the timing model.
  task automatic run(input int i, input string tag);
    int s;
    logic [4:0] em;
    logic [3:0] ev;
    s = settle_of(i);
    ref_model(i, em, ev);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    for (int k = 0; k < 4 * s; k++) begin
      if (busy[i] !== 1'b1) chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy[i]), 1);
      if (done[i] !== 1'b0) chk($sformatf("%s_done_k%0d", tag, k), 32'(done[i]), 0);
      if ({a[i], b[i]} !== 2'(k / s)) chk($sformatf("%s_ab_k%0d", tag, k), 32'({a[i], b[i]}), 32'(k / s));
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_end_busy", tag), 32'(busy[i]), 0);
    chk($sformatf("%s_end_done", tag), 32'(done[i]), 1);
    chk($sformatf("%s_end_ab", tag), 32'({a[i], b[i]}), 0);
    chk($sformatf("%s_pass", tag), 32'(pass[i]), 32'((em == 0) && (ev == 0)));
    chk($sformatf("%s_err_mask", tag), 32'(err_mask[i]), 32'(em));
    chk($sformatf("%s_err_vec", tag), 32'(err_vec[i]), 32'(ev));
  endtask

  initial begin
    rst   = 3'b111;
    start = 3'b000;
    for (int i = 0; i < 3; i++) set_good(i);
    #1;
    for (int i = 0; i < 3; i++) chk_idle_zero(i, $sformatf("reset%0d", i));
    @(negedge clk);
    @(negedge clk);
    rst = 3'b000;

    run(0, "good_s2");

    set_good(0);
    tt[0][1] = 4'b0000;
    run(0, "or_stuck0");

    set_good(0);
    tt[0][2] = 4'b1100;
    run(0, "not_eq_a");

    set_good(0);
    tt[0][3] = 4'b0001;
    tt[0][4] = 4'b0111;
    run(0, "nand_nor_swap");

    for (int r = 0; r < 8; r++) begin
      set_good(0);
      for (int g = 0; g < 5; g++)
        if ($urandom_range(0, 2) == 0) tt[0][g] = 4'($urandom_range(0, 15));
      run(0, $sformatf("rnd%0d", r));
    end

    // start held high with SETTLE=1: a 4-cycle run, one DONE cycle, then an immediate restart.
    run(1, "good_s1");
    @(negedge clk);
    start[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k % 5 < 4) begin
        chk($sformatf("hold_busy_k%0d", k), 32'(busy[1]), 1);
        chk($sformatf("hold_done_k%0d", k), 32'(done[1]), 0);
        chk($sformatf("hold_ab_k%0d", k), 32'({a[1], b[1]}), 32'(k % 5));
        chk($sformatf("hold_mask_k%0d", k), 32'(err_mask[1]), 0);
      end else begin
        chk($sformatf("hold_busy_k%0d", k), 32'(busy[1]), 0);
        chk($sformatf("hold_done_k%0d", k), 32'(done[1]), 1);
        chk($sformatf("hold_pass_k%0d", k), 32'(pass[1]), 1);
      end
    end
    start[1] = 1'b0;

    // Asynchronous reset during vector 2 with a faulty gate, checked before any further clock edge.
    set_good(0);
    tt[0][0] = 4'b1111;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_ab", 32'({a[0], b[0]}), 2);
    chk("pre_rst_mask", 32'(err_mask[0]), 1);
    #1 rst[0] = 1'b1;
    #1 chk_idle_zero(0, "async_rst");
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle_zero(0, "no_resume");
    set_good(0);
    run(0, "after_rst");

    run(2, "good_s255");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
